// File: rtl/sramif_pkg.sv
// Shared types and default geometry for the SRAM-interface access controller.
package sramif_pkg;

  localparam int DEF_AW       = 16;
  localparam int DEF_DW       = 64;
  localparam int DEF_WAIT_CYC = 2;
  localparam int CMD_W        = 1 + DEF_AW + DEF_DW;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    HOLD
  } state_t;

  // FIFO entry layout, MSB first
  typedef struct packed {
    logic                is_wr;
    logic [DEF_AW-1:0]   addr;
    logic [DEF_DW-1:0]   wdata;
  } cmd_t;

endpackage

// File: rtl/sramif_access_ctrl.sv
// Pops packed commands from the command FIFO and runs SETUP/ACCESS/HOLD on an SRAM.
// Optional SRAMIF_BACK2BACK_EN: pop the next command from HOLD, skipping the IDLE gap.
module sramif_access_ctrl
  import sramif_pkg::*;
#(
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int WAIT_CYC = DEF_WAIT_CYC,
  parameter int CMD_W    = 1 + AW + DW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fifo_empty,
  input  logic [CMD_W-1:0] fifo_data,
  output logic             fifo_read,
  output logic             sram_ce_n,
  output logic             sram_we_n,
  output logic             sram_oe_n,
  output logic [AW-1:0]    sram_addr,
  output logic [DW-1:0]    sram_wdata,
  input  logic [DW-1:0]    sram_rdata,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [DW-1:0]    rd_data,
  output logic             busy
);

  generate
    if (WAIT_CYC < 1 || WAIT_CYC > 15) begin : g_bad_wait
      $error("sramif_access_ctrl: WAIT_CYC must be within 1..15");
    end
    if (CMD_W != 1 + AW + DW) begin : g_bad_cmdw
      $error("sramif_access_ctrl: CMD_W must equal 1+AW+DW");
    end
  endgenerate

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic          r_is_wr;
  logic          r_ce_n;
  logic          r_we_n;
  logic          r_oe_n;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_rd_valid;
  logic [DW-1:0] r_rd_data;
  logic          r_busy;

  logic          w_is_wr;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic          w_pending;
  logic          w_pop_state;
  logic          w_pop;

  assign w_is_wr = fifo_data[CMD_W-1];
  assign w_addr  = fifo_data[DW +: AW];
  assign w_wdata = fifo_data[DW-1:0];

  // An unaccepted response blocks further pops: at most one response in flight.
  assign w_pending = r_rd_valid && !rd_ready;

`ifdef SRAMIF_BACK2BACK_EN
  assign w_pop_state = (r_state == IDLE) || (r_state == HOLD);
`else
  assign w_pop_state = (r_state == IDLE);
`endif

  assign w_pop     = rst_n && w_pop_state && !fifo_empty && !w_pending;
  assign fifo_read = w_pop;

  assign sram_ce_n  = r_ce_n;
  assign sram_we_n  = r_we_n;
  assign sram_oe_n  = r_oe_n;
  assign sram_addr  = r_addr;
  assign sram_wdata = r_wdata;
  assign rd_valid   = r_rd_valid;
  assign rd_data    = r_rd_data;
  assign busy       = r_busy;

  // Pin registers are loaded with the values for the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_is_wr    <= 1'b0;
      r_ce_n     <= 1'b1;
      r_we_n     <= 1'b1;
      r_oe_n     <= 1'b1;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_busy     <= 1'b0;
    end else begin
      if (r_rd_valid && rd_ready) r_rd_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_state <= SETUP;
            r_is_wr <= w_is_wr;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_ce_n  <= 1'b0;
            r_we_n  <= 1'b1;
            r_oe_n  <= w_is_wr;
            r_busy  <= 1'b1;
          end
        end
        SETUP: begin
          r_state <= ACCESS;
          r_cnt   <= 4'(WAIT_CYC - 1);
          r_we_n  <= ~r_is_wr;
          r_oe_n  <= r_is_wr;
        end
        ACCESS: begin
          if (r_cnt == 4'd0) begin
            r_state <= HOLD;
            r_we_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            if (!r_is_wr) begin
              r_rd_data  <= sram_rdata;
              r_rd_valid <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        HOLD: begin
          // Address and data stay put through HOLD for write hold time.
          if (w_pop) begin
            r_state <= SETUP;
            r_is_wr <= w_is_wr;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_we_n  <= 1'b1;
            r_oe_n  <= w_is_wr;
          end else begin
            r_state <= IDLE;
            r_ce_n  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sramif_access_ctrl.sv
// Self-checking bench: FIFO + SRAM behavioural models, in-order read scoreboard.
module tb_sramif_access_ctrl;
  import sramif_pkg::*;

  localparam int AW = DEF_AW;
  localparam int DW = DEF_DW;
  localparam int WC = 2;
`ifdef SRAMIF_BACK2BACK_EN
  localparam int GAP = WC + 2;
`else
  localparam int GAP = WC + 3;
`endif
  localparam int CE_HOLES = 3 * (GAP - WC - 2);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic             fifo_empty, fifo_read, sram_ce_n, sram_we_n, sram_oe_n;
  logic [CMD_W-1:0] fifo_data;
  logic [AW-1:0]    sram_addr;
  logic [DW-1:0]    sram_wdata, sram_rdata, rd_data;
  logic             rd_valid, rd_ready, busy;

  logic             fifo_empty15, fifo_read15, ce_n15, we_n15, oe_n15;
  logic [CMD_W-1:0] fifo_data15;
  logic [AW-1:0]    addr15;
  logic [DW-1:0]    wdata15, rdata15, rd_data15;
  logic             rd_valid15, rd_ready15, busy15;

  sramif_access_ctrl #(.WAIT_CYC(WC)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_read(fifo_read), .sram_ce_n(sram_ce_n), .sram_we_n(sram_we_n),
    .sram_oe_n(sram_oe_n), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .busy(busy)
  );

  sramif_access_ctrl #(.WAIT_CYC(15)) dut15 (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty15), .fifo_data(fifo_data15),
    .fifo_read(fifo_read15), .sram_ce_n(ce_n15), .sram_we_n(we_n15),
    .sram_oe_n(oe_n15), .sram_addr(addr15), .sram_wdata(wdata15),
    .sram_rdata(rdata15), .rd_valid(rd_valid15), .rd_ready(rd_ready15),
    .rd_data(rd_data15), .busy(busy15)
  );

  int tests = 0;
  int fails = 0;

  cmd_t        q[$];
  logic [63:0] exp_q[$];
  logic [63:0] mem[logic [15:0]];
  logic [63:0] ref_mem[logic [15:0]];
  int          pops[$];
  int          cyc = 0;
  int          n_we, n_oe, n_ce, ce_first, ce_last, rdv_first;
  logic [15:0] act_addr = '0;
  logic [63:0] act_wdata = '0;
  logic        prev_hold = 1'b0;
  logic [63:0] prev_rd = '0;
  logic [63:0] last_rsp = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sram_val(input logic [15:0] a);
    return mem.exists(a) ? mem[a] : 64'h0;
  endfunction

  // Reference: commands execute in FIFO order, so expected read data is known at push time.
  task automatic push(input logic w, input logic [15:0] a, input logic [63:0] d);
    cmd_t c;
    c.is_wr = w; c.addr = a; c.wdata = d;
    q.push_back(c);
    if (w) ref_mem[a] = d;
    else exp_q.push_back(ref_mem.exists(a) ? ref_mem[a] : 64'h0);
    fifo_empty = 1'b0;
    fifo_data  = q[0];
  endtask

  task automatic clr();
    pops.delete();
    n_we = 0; n_oe = 0; n_ce = 0;
    ce_first = -1; ce_last = -1; rdv_first = -1;
  endtask

  // One clock: sample at negedge, update SRAM/FIFO models, pop after posedge.
  task automatic tick();
    logic pop;
    @(negedge clk);
    cyc++;
    pop = fifo_read;
    if (!sram_we_n) n_we++;
    if (!sram_oe_n) n_oe++;
    if (!sram_ce_n) begin
      n_ce++;
      if (ce_first < 0) ce_first = cyc;
      ce_last = cyc;
      chk("pin_addr", 64'(sram_addr), 64'(act_addr));
      chk("pin_wdata", sram_wdata, act_wdata);
      if (!sram_we_n) mem[sram_addr] = sram_wdata;
    end
    if (pop) begin
      pops.push_back(cyc);
      if (q.size() > 0) begin act_addr = q[0].addr; act_wdata = q[0].wdata; end
    end
    if (rd_valid && rdv_first < 0) rdv_first = cyc;
    if (prev_hold) begin
      chk("rd_valid_held", 64'(rd_valid), 64'd1);
      chk("rd_data_stable", rd_data, prev_rd);
    end
    if (rd_valid && rd_ready) begin
      if (exp_q.size() == 0) chk("unexpected_resp", 64'(exp_q.size()), 64'd1);
      else chk("rd_data", rd_data, exp_q.pop_front());
      last_rsp = rd_data;
    end
    prev_hold  = rd_valid && !rd_ready;
    prev_rd    = rd_data;
    sram_rdata = (!sram_ce_n && !sram_oe_n) ? sram_val(sram_addr) : 64'h0;
    @(posedge clk);
    #1;
    if (pop && q.size() > 0) void'(q.pop_front());
    fifo_empty = (q.size() == 0);
    fifo_data  = fifo_empty ? '0 : q[0];
  endtask

  task automatic drain(input string tag);
    rd_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (q.size() == 0 && !busy && !rd_valid) break;
      tick();
    end
    chk(tag, 64'(q.size() == 0 && !busy && !rd_valid), 64'd1);
  endtask

  initial begin
    logic [63:0] a15, b15, c15;
    int p15, rv15, oe15, np15, nr;
    rst_n = 1'b0;
    fifo_empty = 1'b1; fifo_data = '0; sram_rdata = '0; rd_ready = 1'b1;
    fifo_empty15 = 1'b1; fifo_data15 = '0; rdata15 = '0; rd_ready15 = 1'b1;
    #12;
    chk("rst_fifo_read", 64'(fifo_read), 64'd0);
    chk("rst_ce_n", 64'(sram_ce_n), 64'd1);
    chk("rst_we_n", 64'(sram_we_n), 64'd1);
    chk("rst_oe_n", 64'(sram_oe_n), 64'd1);
    chk("rst_addr", 64'(sram_addr), 64'd0);
    chk("rst_wdata", sram_wdata, 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd_data", rd_data, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // single write
    clr();
    push(1'b1, 16'h0010, 64'hA5A5_0000_FFFF_1234);
    drain("wr_drain");
    chk("wr_pops", 64'(pops.size()), 64'd1);
    chk("wr_we_cycles", 64'(n_we), 64'(WC));
    chk("wr_ce_cycles", 64'(n_ce), 64'(WC + 2));
    chk("wr_no_rdv", 64'(rdv_first), 64'(-1));
    chk("wr_mem", sram_val(16'h0010), 64'hA5A5_0000_FFFF_1234);

    // single read
    mem[16'h0011] = 64'hDEAD_BEEF_0000_0001;
    ref_mem[16'h0011] = 64'hDEAD_BEEF_0000_0001;
    clr();
    push(1'b0, 16'h0011, 64'h0);
    drain("rd_drain");
    chk("rd_latency", 64'(rdv_first - (pops.size() > 0 ? pops[0] : 0)), 64'd4);
    chk("rd_value", last_rsp, 64'hDEAD_BEEF_0000_0001);
    chk("rd_oe_cycles", 64'(n_oe), 64'(WC + 1));
    chk("rd_we_cycles", 64'(n_we), 64'd0);

    // backpressure with queued commands
    clr();
    rd_ready = 1'b0;
    push(1'b0, 16'h0010, 64'h0);
    push(1'b1, 16'h0012, 64'h1212_1212_0000_0012);
    push(1'b1, 16'h0013, 64'h1313_1313_0000_0013);
    push(1'b0, 16'h0012, 64'h0);
    for (int i = 0; i < 20 && rdv_first < 0; i++) tick();
    chk("bp_rdv_seen", 64'(rdv_first >= 0), 64'd1);
    repeat (10) tick();
    chk("bp_no_pop", 64'(pops.size()), 64'd1);
    chk("bp_rd_data", rd_data, 64'hA5A5_0000_FFFF_1234);
    rd_ready = 1'b1;
    tick();
    chk("bp_pop_count", 64'(pops.size()), 64'd2);
    chk("bp_pop_cycle", 64'(pops.size() > 1 ? pops[1] : -1), 64'(cyc));
    drain("bp_drain");

    // four back-to-back writes
    clr();
    for (int i = 0; i < 4; i++) push(1'b1, 16'(16'h0020 + i), {32'hB2B0_0000, 32'(i)});
    drain("b2b_drain");
    chk("b2b_pops", 64'(pops.size()), 64'd4);
    for (int i = 1; i < 4 && i < pops.size(); i++)
      chk("b2b_spacing", 64'(pops[i] - pops[i-1]), 64'(GAP));
    chk("b2b_ce_span", 64'(ce_last - ce_first + 1), 64'(n_ce + CE_HOLES));
    chk("b2b_ce_total", 64'(n_ce), 64'(4 * (WC + 2)));

    // reset during second ACCESS cycle of a write
    clr();
    push(1'b1, 16'h0BAD, 64'h0123_4567_89AB_CDEF);
    for (int i = 0; i < 10 && pops.size() == 0; i++) tick();
    chk("rstm_pop", 64'(pops.size()), 64'd1);
    tick(); tick();
    #2;
    chk("rstm_in_access", 64'(sram_we_n), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("rstm_ce_n", 64'(sram_ce_n), 64'd1);
    chk("rstm_we_n", 64'(sram_we_n), 64'd1);
    chk("rstm_busy", 64'(busy), 64'd0);
    push(1'b0, 16'h0011, 64'h0);
    repeat (3) begin
      tick();
      chk("rstm_fifo_read", 64'(fifo_read), 64'd0);
      chk("rstm_oe_n", 64'(sram_oe_n), 64'd1);
      chk("rstm_addr", 64'(sram_addr), 64'd0);
      chk("rstm_rd_valid", 64'(rd_valid), 64'd0);
    end
    rst_n = 1'b1;
    drain("rstm_drain");
    chk("rstm_after_read", last_rsp, 64'hDEAD_BEEF_0000_0001);

    // randomized traffic with random response backpressure
    nr = 0;
    for (int i = 0; i < 400; i++) begin
      if (nr < 40 && $urandom_range(0, 2) == 0) begin
        push(1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), {$urandom(), $urandom()});
        nr++;
      end
      rd_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain("rand_drain");
    chk("rand_resp_left", 64'(exp_q.size()), 64'd0);

    // WAIT_CYC=15 read: data must be sampled only on the 15th ACCESS cycle
    a15 = 64'h1111_1111_1111_1111;
    b15 = 64'h2222_2222_2222_2222;
    c15 = 64'h3333_3333_3333_3333;
    p15 = -1; rv15 = -1; oe15 = 0; np15 = 0;
    rdata15 = a15;
    fifo_data15 = {1'b0, 16'h0005, 64'h0};
    fifo_empty15 = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (fifo_read15) begin np15++; if (p15 < 0) p15 = k; end
      if (!oe_n15) oe15++;
      if (rd_valid15 && rv15 < 0) begin
        rv15 = k;
        chk("w15_rd_data", rd_data15, b15);
      end
      if (p15 >= 0) rdata15 = (k - p15 == 16) ? b15 : ((k - p15 == 17) ? c15 : a15);
      @(posedge clk); #1;
      if (k == p15) fifo_empty15 = 1'b1;
    end
    chk("w15_pops", 64'(np15), 64'd1);
    chk("w15_latency", 64'(rv15 - p15), 64'd17);
    chk("w15_oe_cycles", 64'(oe15), 64'd16);
    chk("w15_idle", 64'(busy15), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
